// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch stage sitting between instruction memory and decode.
//
// It keeps the fetch PC, which starts at BOOT_ADDRESS. It issues one word request at a time
// over a req/gnt/rvalid interface. Returned words go into a small FIFO, and decode reads them
// through a valid/ready handshake. A redirect flushes every buffered word and drops any response
// that is still in flight.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   instr_req_o/addr_o      memory request and its word-aligned address
//   instr_gnt_i             request accepted this cycle
//   instr_rvalid_i/rdata_i  read response
//   redirect_i/addr_i       PC redirect strobe and target
//   instr_valid_o/ready_i   handshake towards decode
//   instr_o, instr_pc_o     FIFO head word and its PC (zero while invalid)
//   busy_o                  request outstanding or FIFO non-empty
//
// Optional feature: define IF_FETCH_PERF_CNT_EN to add the saturating counters perf_fetched_o
// (FIFO pushes) and perf_stall_o (cycles where decode is ready but nothing is valid).
module if_fetch_stage #(
  parameter int unsigned                 INSTR_ADDR_WIDTH = 32,
  parameter int unsigned                 INSTR_WORD_WIDTH = 32,
  parameter logic [INSTR_ADDR_WIDTH-1:0] BOOT_ADDRESS     = '0,
  parameter int unsigned                 FIFO_DEPTH       = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        instr_req_o,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                        instr_gnt_i,
  input  logic                        instr_rvalid_i,
  input  logic [INSTR_WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                        redirect_i,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                        instr_valid_o,
  output logic [INSTR_WORD_WIDTH-1:0] instr_o,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_pc_o,
  input  logic                        instr_ready_i,
  output logic                        busy_o
`ifdef IF_FETCH_PERF_CNT_EN
  ,
  output logic [31:0]                 perf_fetched_o,
  output logic [31:0]                 perf_stall_o
`endif
);

  localparam int unsigned   PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                      r_state, w_state_nxt;
  logic [INSTR_ADDR_WIDTH-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic [INSTR_ADDR_WIDTH-1:0] r_req_pc, w_req_pc_nxt;
  logic                        r_drop, w_drop_nxt;

  logic [INSTR_WORD_WIDTH-1:0] r_fifo_instr [FIFO_DEPTH];
  logic [INSTR_ADDR_WIDTH-1:0] r_fifo_pc    [FIFO_DEPTH];
  logic [PtrW-1:0]             r_wptr, r_rptr;
  logic [PtrW:0]               r_count, w_count_nxt;

  logic                        w_push, w_pop, w_slot_free;
  logic [INSTR_ADDR_WIDTH-1:0] w_redirect_pc;
  logic                        w_unused_addr_bits;

  assign w_redirect_pc      = {redirect_addr_i[INSTR_ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_addr_bits = ^redirect_addr_i[1:0];

  assign w_pop  = (r_count != '0) && instr_ready_i;
  // The response that arrives with a redirect belongs to the old path, so it is discarded.
  assign w_push = (r_state == StWait) && instr_rvalid_i && !r_drop && !redirect_i;

  always_comb begin
    w_count_nxt = r_count + (PtrW + 1)'(w_push) - (PtrW + 1)'(w_pop);
    if (redirect_i) begin
      w_count_nxt = '0;
    end
  end

  // The slot check uses the post-update occupancy, so a pop in the same cycle frees a slot.
  assign w_slot_free = w_count_nxt < DepthCnt;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_pc_nxt   = r_req_pc;
    w_drop_nxt     = r_drop;
    case (r_state)
      StIdle: begin
        if (w_slot_free && !redirect_i) begin
          w_state_nxt = StReq;
        end
      end
      StReq: begin
        if (instr_gnt_i) begin
          w_req_pc_nxt   = r_fetch_pc;
          w_fetch_pc_nxt = r_fetch_pc + INSTR_ADDR_WIDTH'(4);
          w_state_nxt    = StWait;
          w_drop_nxt     = redirect_i;
        end
      end
      StWait: begin
        if (instr_rvalid_i) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = w_slot_free ? StReq : StIdle;
        end else if (redirect_i) begin
          w_drop_nxt = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    // A request in StReq that is not granted is simply reissued at the new PC.
    if (redirect_i) begin
      w_fetch_pc_nxt = w_redirect_pc;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= StIdle;
      r_fetch_pc <= BOOT_ADDRESS;
      r_req_pc   <= '0;
      r_drop     <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_pc   <= w_req_pc_nxt;
      r_drop     <= w_drop_nxt;
      r_count    <= w_count_nxt;
      if (redirect_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + PtrW'(1);
        if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only observed through a non-zero count.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= instr_rdata_i;
      r_fifo_pc[r_wptr]    <= r_req_pc;
    end
  end

  assign instr_valid_o = (r_count != '0);
  assign instr_o       = instr_valid_o ? r_fifo_instr[r_rptr] : '0;
  assign instr_pc_o    = instr_valid_o ? r_fifo_pc[r_rptr] : '0;
  assign instr_req_o   = (r_state == StReq);
  assign instr_addr_o  = instr_req_o ? r_fetch_pc : '0;
  assign busy_o        = (r_state == StWait) || instr_valid_o;

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched, r_perf_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push && (r_perf_fetched != '1)) begin
        r_perf_fetched <= r_perf_fetched + 32'd1;
      end
      if (instr_ready_i && !instr_valid_o && (r_perf_stall != '1)) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_fetched_o = r_perf_fetched;
  assign perf_stall_o   = r_perf_stall;
`endif

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction fetch stage directly upstream of decode and downstream of the instruction memory.
- Holds the fetch PC, starts at BOOT_ADDRESS after reset, and issues word requests over a req/gnt/rvalid interface.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Accepts redirects from branch/jump resolution, flushing in-flight and buffered instructions.

Parameters:
- BOOT_ADDRESS, 32'h00000000, PC loaded on reset.
- INSTR_ADDR_WIDTH, 32, instruction address width.
- INSTR_WORD_WIDTH, 32, instruction word width.
- FIFO_DEPTH, 2, fetch buffer entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- instr_req_o  out  1  memory request.
- instr_addr_o  out  INSTR_ADDR_WIDTH  request address, word aligned.
- instr_gnt_i  in  1  request accepted this cycle.
- instr_rvalid_i  in  1  read data valid.
- instr_rdata_i  in  INSTR_WORD_WIDTH  read data.
- redirect_i  in  1  PC redirect strobe.
- redirect_addr_i  in  INSTR_ADDR_WIDTH  redirect target.
- instr_valid_o  out  1  instruction available to decode.
- instr_o  out  INSTR_WORD_WIDTH  instruction word.
- instr_pc_o  out  INSTR_ADDR_WIDTH  PC of instr_o.
- instr_ready_i  in  1  decode accepts.
- busy_o  out  1  request outstanding or FIFO non-empty.

Behaviour:
- Interface:
  - One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values:
  - fetch_pc = BOOT_ADDRESS.
  - FIFO empty, outstanding = 0, drop flag = 0.
  - Outputs: instr_req_o = 0, instr_valid_o = 0, busy_o = 0.
  - instr_o, instr_pc_o, instr_addr_o = 0 while invalid.
- Request state machine:
  - States are IDLE, REQ and WAIT. At most one request is outstanding.
  - IDLE -> REQ when free FIFO slots > 0 and not redirecting (free slots = FIFO_DEPTH - count).
  - REQ: instr_req_o = 1 and instr_addr_o = fetch_pc. Both are held stable until instr_gnt_i.
  - On gnt: store the request PC, fetch_pc += 4, go to WAIT.
  - WAIT: on instr_rvalid_i, push {rdata, req PC} unless the drop flag is set. Then go to REQ if a slot is free, else IDLE.
- Memory timing:
  - rvalid arrives at least 1 cycle after gnt.
  - gnt and rvalid in the same cycle apply to different requests; both are legal.
- Output:
  - instr_valid_o = FIFO non-empty.
  - instr_o and instr_pc_o are the FIFO head.
  - Pop when instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle while full is legal, because the slot check counts the pop.
- Latency:
  - Single-cycle gnt and rvalid gives a redirect-to-instr_valid_o latency of 3 cycles: REQ, WAIT, then push visible.
  - Steady-state throughput is 1 instruction per 2 cycles per outstanding slot.
- Redirect (highest priority):
  - Flush the FIFO and set fetch_pc = {redirect_addr_i[31:2], 2'b00}.
  - In WAIT, set the drop flag; the next rvalid is discarded and clears the flag.
  - In REQ without gnt, the request is withdrawn next cycle and reissued at the new address. In REQ with gnt the same cycle, go to WAIT with the drop flag set.
  - Redirect and rvalid in the same cycle: the data is discarded.
  - Redirect and pop in the same cycle: the flush wins.
- Wrap-around: fetch_pc 32'hFFFFFFFC + 4 = 32'h00000000, no flag.
- Stray response: rvalid with outstanding = 0 is ignored.
- Reset mid-operation: all state returns to reset values. No pre-reset response is pushed.

Optional Feature:
- IF_FETCH_PERF_CNT_EN defined:
  - Adds two ports, perf_fetched_o (out, 32) and perf_stall_o (out, 32).
  - perf_fetched_o counts FIFO pushes.
  - perf_stall_o counts cycles with instr_ready_i = 1 and instr_valid_o = 0.
  - Both reset to 0, saturate at 32'hFFFFFFFF, and are not cleared by redirect.
- Not defined: the ports and counters are absent.

Test Plan:
- Reset, always-gnt 1-cycle memory returning addr-tagged data, ready = 1 -> instr_addr_o sequence 0x0, 0x4, 0x8. instr_pc_o matches. First instr_valid_o 3 cycles after reset deassert.
- ready = 0 for 10 cycles -> exactly 2 pushes, then instr_req_o = 0. Release ready -> 2 pops in order 0x0, 0x4, then fetch resumes at 0x8.
- Redirect to 0x103 while in WAIT -> returning word dropped, next instr_addr_o = 0x100, first instr_pc_o = 0x100.
- gnt held low 5 cycles -> instr_req_o and instr_addr_o stable for all 5 cycles. Redirect on cycle 3 -> address changes to the target next cycle.
- redirect_addr_i = 0xFFFFFFFC -> fetched PCs 0xFFFFFFFC then 0x00000000.
- Assert rst_i while WAIT with FIFO full -> next cycle instr_valid_o = 0, rvalid ignored, fetch restarts at BOOT_ADDRESS. With IF_FETCH_PERF_CNT_EN, counters read 0.
